// File: rtl/mtr_drv.sv
// Dual-channel H-bridge PWM driver: offset-binary duty, period-boundary duty update, dead time.
// Optional MTR_SLEW_EN limits per-period duty change to SLEW_STEP.
module mtr_drv #(
    parameter int unsigned NONOVERLAP = 32,
    parameter int unsigned SLEW_STEP  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2
);

    localparam logic [7:0] DEAD_MAX = NONOVERLAP[7:0];

    // Channel 0 is left, channel 1 is right.
    logic [10:0] cnt;
    logic [10:0] target   [2];
    logic [10:0] duty_nxt [2];
    logic [10:0] duty_q   [2];
    logic        raw      [2];
    logic        raw_q    [2];
    logic [7:0]  dead_cnt [2];
    logic        settled  [2];
    logic        pwm1_q   [2];
    logic        pwm2_q   [2];

    always_comb begin
        target[0] = {~lft_spd[10], lft_spd[9:0]};
        target[1] = {~rght_spd[10], rght_spd[9:0]};
        for (int unsigned ch = 0; ch < 2; ch++) begin
            raw[ch]     = (cnt < duty_q[ch]);
            settled[ch] = (dead_cnt[ch] == DEAD_MAX);
        end
    end

`ifdef MTR_SLEW_EN
    localparam logic signed [11:0] STEP_S = 12'(SLEW_STEP);
    localparam logic        [10:0] STEP_U = 11'(SLEW_STEP);

    logic signed [11:0] diff [2];

    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            diff[ch] = $signed({1'b0, target[ch]}) - $signed({1'b0, duty_q[ch]});
            if (diff[ch] > STEP_S)
                duty_nxt[ch] = duty_q[ch] + STEP_U;
            else if (diff[ch] < -STEP_S)
                duty_nxt[ch] = duty_q[ch] - STEP_U;
            else
                duty_nxt[ch] = target[ch];
        end
    end
`else
    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++)
            duty_nxt[ch] = target[ch];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                duty_q[ch]   <= 11'h400;
                raw_q[ch]    <= 1'b0;
                dead_cnt[ch] <= '0;
                pwm1_q[ch]   <= 1'b0;
                pwm2_q[ch]   <= 1'b0;
            end
        end else begin
            cnt <= cnt + 11'd1;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (cnt == '1)
                    duty_q[ch] <= duty_nxt[ch];
                raw_q[ch] <= raw[ch];
                // Restart dead time on the cycle raw_q is about to toggle.
                if (raw[ch] != raw_q[ch])
                    dead_cnt[ch] <= '0;
                else if (!settled[ch])
                    dead_cnt[ch] <= dead_cnt[ch] + 8'd1;
                pwm1_q[ch] <= raw_q[ch] & settled[ch];
                pwm2_q[ch] <= ~raw_q[ch] & settled[ch];
            end
        end
    end

    assign lftPWM1  = pwm1_q[0];
    assign lftPWM2  = pwm2_q[0];
    assign rghtPWM1 = pwm1_q[1];
    assign rghtPWM2 = pwm2_q[1];

endmodule

// File: tb/tb_mtr_drv.sv
// Directed self-checking bench for mtr_drv; counts output high cycles over cnt-aligned windows.
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = '0;
    logic [10:0] rght_spd = '0;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;

    int passed = 0;
    int total  = 0;
    int l1, l2, r1, r2;
    int ov_l = 0;
    int ov_r = 0;
    logic [10:0] tb_cnt;

    mtr_drv #(.NONOVERLAP(32), .SLEW_STEP(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2)
    );

    always #5 clk = ~clk;

    // Reference period counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 11'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_cnt(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (int'(tb_cnt) == target) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("wait_timeout", 0, 1);
    endtask

    // Samples the current negedge plus len-1 following ones.
    task automatic count(input int len);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            l1 += int'(lftPWM1);
            l2 += int'(lftPWM2);
            r1 += int'(rghtPWM1);
            r2 += int'(rghtPWM2);
            ov_l += int'(lftPWM1 & lftPWM2);
            ov_r += int'(rghtPWM1 & rghtPWM2);
        end
    endtask

    task automatic period();
        wait_cnt(0);
        count(2048);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_l1", int'(lftPWM1), 0);
        chk("rst_l2", int'(lftPWM2), 0);
        chk("rst_r1", int'(rghtPWM1), 0);
        chk("rst_r2", int'(rghtPWM2), 0);
        rst_n = 1'b1;

        // First NONOVERLAP+2 cycles all low
        count(34);
        chk("start_l1", l1, 0);
        chk("start_l2", l2, 0);
        chk("start_r1", r1, 0);
        chk("start_r2", r2, 0);
        count(2014);

        // 50% steady state
        for (int p = 0; p < 3; p++) begin
            period();
            chk("p50_l1", l1, 992);
            chk("p50_l2", l2, 992);
            chk("p50_r1", r1, 992);
            chk("p50_r2", r2, 992);
        end

`ifdef MTR_SLEW_EN
        wait_cnt(100);
        lft_spd = 11'sd1023;
        for (int k = 1; k <= 15; k++) begin
            period();
            chk("slew_l1", l1, 1024 + 64 * k - 32);
        end
        period();
        period();
        chk("slew_final_l1", l1, 2015);
`else
        // Full forward: 1-cycle raw low is swallowed by dead time
        lft_spd = 11'sd1023;
        period();
        period();
        chk("fwd_l1", l1, 2015);
        chk("fwd_l2", l2, 0);
        chk("fwd_r1", r1, 992);
        chk("fwd_r2", r2, 992);

        // Full reverse
        lft_spd = 11'h400;
        period();
        period();
        chk("rev_l1", l1, 0);
        chk("rev_l2", l2, 2048);

        // Mid-period command change waits for the boundary
        wait_cnt(700);
        rght_spd = 11'sd512;
        count(1348);
        chk("mid_r1", r1, 326);
        chk("mid_r2", r2, 990);
        period();
        chk("new_r1", r1, 1504);
        chk("new_r2", r2, 480);

        // Asynchronous reset mid-period
        lft_spd = 11'sd300;
        wait_cnt(500);
        chk("pre_rst_r1", int'(rghtPWM1), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_l1", int'(lftPWM1), 0);
        chk("arst_l2", int'(lftPWM2), 0);
        chk("arst_r1", int'(rghtPWM1), 0);
        chk("arst_r2", int'(rghtPWM2), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count(2048);
        chk("post_rst_l1", l1, 992);
        chk("post_rst_r1", r1, 992);
        period();
        chk("p1324_l1", l1, 1292);
        chk("p1324_l2", l2, 692);
        chk("p1536_r1", r1, 1504);
`endif

        chk("overlap_l", ov_l, 0);
        chk("overlap_r", ov_r, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
